// File: rtl/rx_mac_interface_pkg.sv
// Shared definitions for the MAC RX/TX frame-ring paths: FSM states, ring geometry,
// header field layout and a byte-valid popcount helper.
package rx_mac_interface_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StHdr,
        StCommit,
        StDrop
    } rx_state_e;

    localparam int unsigned RING_DEPTH    = 512;
    localparam int unsigned PTR_W         = 10;
    localparam int unsigned ADDR_W        = 9;
    localparam int unsigned BYTE_CNT_W    = 16;
    localparam int unsigned HDR_BYTES_MSB = 63;
    localparam int unsigned HDR_BYTES_LSB = 32;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rx_mac_interface.sv
// Writes MAC RX frames into the frame ring as [header][data...] and publishes the
// write pointer only once a good frame is completely stored.
module rx_mac_interface
    import rx_mac_interface_pkg::*;
#(
    parameter int unsigned MAX_QWORDS = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       rx_data,
    input  logic [7:0]        rx_data_valid,
    input  logic              rx_good_frame,
    input  logic              rx_bad_frame,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              wr_en,
    output logic [PTR_W-1:0]  commited_wr_addr,
    input  logic [PTR_W-1:0]  commited_rd_addr,
    output logic [31:0]       dropped_frames
);

    localparam int unsigned      QW_W     = $clog2(MAX_QWORDS + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(RING_DEPTH);

    rx_state_e              state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       sof_ptr_q, sof_ptr_d;
    logic [PTR_W-1:0]       commit_q, commit_d;
    logic [31:0]            dropped_q, dropped_d;
    logic [BYTE_CNT_W-1:0]  bytes_q, bytes_d;
    logic [QW_W-1:0]        qwords_q, qwords_d;
    logic                   late_q, late_d;

    logic                   beat, frame_end, is_good, full, hdr_full, qw_limit, accept, drop_inc;
    logic [BYTE_CNT_W-1:0]  beat_bytes;

    assign beat       = |rx_data_valid;
    assign frame_end  = rx_good_frame | rx_bad_frame;
    assign is_good    = rx_good_frame & ~rx_bad_frame;
    assign full       = (wr_ptr_q - commited_rd_addr) == PTR_FULL;
    assign hdr_full   = (commit_q - commited_rd_addr) == PTR_FULL;
    assign qw_limit   = qwords_q == QW_W'(MAX_QWORDS);
    assign beat_bytes = BYTE_CNT_W'(popcount8(rx_data_valid));
    assign accept     = beat && !full &&
                        ((state_q == StIdle && !hdr_full) || (state_q == StRecv && !qw_limit));

    assign commited_wr_addr = commit_q;
    assign dropped_frames   = dropped_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            sof_ptr_q <= '0;
            commit_q  <= '0;
            dropped_q <= '0;
            bytes_q   <= '0;
            qwords_q  <= '0;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            sof_ptr_q <= sof_ptr_d;
            commit_q  <= commit_d;
            dropped_q <= dropped_d;
            bytes_q   <= bytes_d;
            qwords_q  <= qwords_d;
            late_q    <= late_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        sof_ptr_d = sof_ptr_q;
        commit_d  = commit_q;
        bytes_d   = bytes_q;
        qwords_d  = qwords_q;
        late_d    = late_q;
        drop_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                sof_ptr_d = commit_q;
                wr_ptr_d  = commit_q + PTR_ONE;
                if (beat && !accept) begin
                    if (frame_end) drop_inc = 1'b1;
                    else           state_d  = StDrop;
                end else if (beat && (!frame_end || is_good)) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    bytes_d  = beat_bytes;
                    qwords_d = QW_W'(1);
                    state_d  = frame_end ? StHdr : StRecv;
                end else if (frame_end) begin
                    // Bad single-beat frame, lone bad pulse or runt good pulse.
                    drop_inc = 1'b1;
                end
            end
            StRecv: begin
                if (beat && !accept) begin
                    if (frame_end) begin
                        drop_inc = 1'b1;
                        wr_ptr_d = sof_ptr_q + PTR_ONE;
                        state_d  = StIdle;
                    end else begin
                        state_d = StDrop;
                    end
                end else begin
                    if (beat) begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        bytes_d  = bytes_q + beat_bytes;
                        qwords_d = qwords_q + QW_W'(1);
                    end
                    if (frame_end && is_good) begin
                        state_d = StHdr;
                    end else if (frame_end) begin
                        drop_inc = 1'b1;
                        wr_ptr_d = sof_ptr_q + PTR_ONE;
                        state_d  = StIdle;
                    end
                end
            end
            StHdr, StCommit: begin
                // A frame starting inside the header/commit gap is counted once, here.
                if (!late_q && (beat || frame_end)) drop_inc = 1'b1;
                late_d = (late_q | beat) & ~frame_end;
                if (state_q == StHdr) begin
                    commit_d = wr_ptr_q;
                    state_d  = StCommit;
                end else begin
                    sof_ptr_d = commit_q;
                    wr_ptr_d  = commit_q + PTR_ONE;
                    state_d   = late_d ? StDrop : StIdle;
                end
            end
            StDrop: begin
                if (frame_end) begin
                    if (!late_q) drop_inc = 1'b1;
                    late_d   = 1'b0;
                    wr_ptr_d = sof_ptr_q + PTR_ONE;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        dropped_d = dropped_q + 32'(drop_inc);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_ptr_q[ADDR_W-1:0];
        wr_data = '0;
        if (state_q == StHdr) begin
            wr_en   = 1'b1;
            wr_addr = sof_ptr_q[ADDR_W-1:0];
            wr_data[HDR_BYTES_MSB:HDR_BYTES_LSB] = 32'(bytes_q);
        end else if (accept) begin
            wr_en   = 1'b1;
            wr_data = rx_data;
        end
        if (!reset_n) begin
            wr_en   = 1'b0;
            wr_data = '0;
        end
    end

endmodule
